// File: rtl/dac_spi_frame_decoder.sv
// Oversampling receive-side decoder for AD5662-style 24-bit SPI frames.
// Tracks a shadow copy of the DAC register and keeps saturating frame statistics.
module dac_spi_frame_decoder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] RESET_VALUE = 16'h8000,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 dataclk,
    input  logic                 reset,
    input  logic                 DAC_SYNC,
    input  logic                 DAC_SCLK,
    input  logic                 DAC_DIN,
    input  logic                 enable,
    input  logic                 clear_counters,
    output logic                 word_valid,
    output logic [5:0]           word_dc,
    output logic [1:0]           word_pd,
    output logic [15:0]          word_data,
    output logic [15:0]          DAC_value,
    output logic [1:0]           pd_mode,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] abort_count,
    output logic [CNT_WIDTH-1:0] overlength_count
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE_WAIT} state_e;

    // Top bit of the SYNC/SCLK chains is the extra delay flop used for edge detection.
    logic [SYNC_STAGES:0]   sync_q;
    logic [SYNC_STAGES:0]   sclk_q;
    logic [SYNC_STAGES-1:0] din_q;

    always_ff @(posedge dataclk) begin
        if (!reset) begin
            sync_q <= '1;
            sclk_q <= '0;
            din_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], DAC_SYNC};
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], DAC_SCLK};
            din_q  <= {din_q[SYNC_STAGES-2:0], DAC_DIN};
        end
    end

    logic sync_dly, sync_fall, sync_rise, sclk_sample, din_s;
    assign sync_dly    = sync_q[SYNC_STAGES];
    assign sync_fall   = sync_dly & ~sync_q[SYNC_STAGES-1];
    assign sync_rise   = ~sync_dly & sync_q[SYNC_STAGES-1];
    assign sclk_sample = sclk_q[SYNC_STAGES] & ~sclk_q[SYNC_STAGES-1] & ~sync_dly;
    assign din_s       = din_q[SYNC_STAGES-1];

    state_e      state_q, state_d;
    logic [4:0]  bit_cnt_q;
    logic [22:0] shreg_q;       // only 23 bits need storing; the 24th arrives with the accept
    logic        ovl_seen_q;
    logic [23:0] shreg_next;
    logic        last_bit;

    assign shreg_next = {shreg_q, din_s};
    assign last_bit   = (bit_cnt_q == 5'd23);

    always_ff @(posedge dataclk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sync_fall && enable) state_d = SHIFT;
            end
            SHIFT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sclk_sample && last_bit) begin
                    state_d = sync_rise ? IDLE : DONE_WAIT;
                end else if (sync_rise) begin
                    state_d = IDLE;
                end
            end
            DONE_WAIT: begin
                if (!enable || sync_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic start_frame, shift_en, accept, abort, ovl_inc;

    always_comb begin
        start_frame = 1'b0;
        shift_en    = 1'b0;
        accept      = 1'b0;
        abort       = 1'b0;
        ovl_inc     = 1'b0;
        case (state_q)
            IDLE:      start_frame = sync_fall && enable;
            SHIFT: begin
                if (enable) begin
                    shift_en = sclk_sample;
                    accept   = sclk_sample && last_bit;
                    abort    = sync_rise && !(sclk_sample && last_bit);
                end
            end
            DONE_WAIT: ovl_inc = enable && sclk_sample && !ovl_seen_q;
            default: ;
        endcase
    end

    logic        word_valid_q, busy_q;
    logic [5:0]  word_dc_q;
    logic [1:0]  word_pd_q, pd_mode_q;
    logic [15:0] word_data_q, dac_value_q;

    always_ff @(posedge dataclk) begin
        if (!reset) begin
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            ovl_seen_q   <= 1'b0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            word_dc_q    <= '0;
            word_pd_q    <= '0;
            word_data_q  <= '0;
            pd_mode_q    <= '0;
            dac_value_q  <= RESET_VALUE;
        end else begin
            word_valid_q <= accept;
            busy_q       <= (state_d != IDLE);
            if (start_frame) begin
                bit_cnt_q  <= '0;
                shreg_q    <= '0;
                ovl_seen_q <= 1'b0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
                shreg_q   <= shreg_next[22:0];
            end
            if (ovl_inc) ovl_seen_q <= 1'b1;
            if (accept) begin
                word_dc_q   <= shreg_next[23:18];
                word_pd_q   <= shreg_next[17:16];
                word_data_q <= shreg_next[15:0];
                pd_mode_q   <= shreg_next[17:16];
                dac_value_q <= shreg_next[15:0];
            end
        end
    end

    logic [2:0]           cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_val [3];
    assign cnt_inc = {ovl_inc, abort, accept};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_q;
            // Clear wins over a same-cycle increment; counters stick at all-ones.
            always_ff @(posedge dataclk) begin
                if (!reset || clear_counters) begin
                    cnt_q <= '0;
                end else if (cnt_inc[gi] && !(&cnt_q)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign word_valid       = word_valid_q;
    assign word_dc          = word_dc_q;
    assign word_pd          = word_pd_q;
    assign word_data        = word_data_q;
    assign DAC_value        = dac_value_q;
    assign pd_mode          = pd_mode_q;
    assign busy             = busy_q;
    assign frame_count      = cnt_val[0];
    assign abort_count      = cnt_val[1];
    assign overlength_count = cnt_val[2];

endmodule
